// File: rtl/ss_pulse_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
package ss_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } ss_state_e;

  function automatic int cnt_w(input int w, input int g);
    int m;
    m = (w > g) ? w : g;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ss_pulse_stretch.sv
// Strobe to fixed-width pulse stretcher with a minimum low gap.
// Optional SS_PULSE_RETRIGGER_EN: events during HIGH extend the pulse.
module ss_pulse_stretch
  import ss_pulse_pkg::*;
#(
  parameter int WIDTH_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pulse,
  output logic o_signal,
  output logic o_busy,
  output logic o_drop
);

  localparam int CNT_W = cnt_w(WIDTH_CYC, GAP_CYC);
  localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WIDTH_CYC - 1);
  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP_CYC - 1);

  if (WIDTH_CYC < 1 || GAP_CYC < 1) begin : g_bad_param
    $fatal(1, "ss_pulse_stretch: WIDTH_CYC and GAP_CYC must be >= 1");
  end

  ss_state_e        r_state;
  ss_state_e        w_nstate;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_ncnt;
  logic             r_pend;
  logic             w_npend;
  logic             w_ndrop;
  logic             w_queue;
  logic             w_cnt_z;
  logic             r_signal;
  logic             r_busy;
  logic             r_drop;

  assign w_cnt_z = (r_cnt == '0);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_npend  = r_pend;
    w_ndrop  = 1'b0;
    w_queue  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_pulse) begin
          w_nstate = HIGH;
          w_ncnt   = W_LOAD;
        end
      end
      HIGH: begin
`ifdef SS_PULSE_RETRIGGER_EN
        if (i_pulse) begin
          w_ncnt = W_LOAD;
        end else if (w_cnt_z) begin
          w_nstate = GAP;
          w_ncnt   = G_LOAD;
        end else begin
          w_ncnt = r_cnt - 1'b1;
        end
`else
        w_queue = i_pulse;
        if (w_cnt_z) begin
          w_nstate = GAP;
          w_ncnt   = G_LOAD;
        end else begin
          w_ncnt = r_cnt - 1'b1;
        end
`endif
      end
      GAP: begin
        if (w_cnt_z) begin
          if (r_pend) begin
            w_nstate = HIGH;
            w_ncnt   = W_LOAD;
            w_npend  = 1'b0;
            w_queue  = i_pulse;
          end else if (i_pulse) begin
            w_nstate = HIGH;
            w_ncnt   = W_LOAD;
          end else begin
            w_nstate = IDLE;
          end
        end else begin
          w_ncnt  = r_cnt - 1'b1;
          w_queue = i_pulse;
        end
      end
      default: begin
        w_nstate = IDLE;
        w_ncnt   = '0;
        w_npend  = 1'b0;
      end
    endcase
    // A consumed pend frees the slot for an event in the same cycle.
    if (w_queue) begin
      if (w_npend) w_ndrop = 1'b1;
      else         w_npend = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_signal <= 1'b0;
      r_busy   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_cnt    <= w_ncnt;
      r_pend   <= w_npend;
      r_signal <= (w_nstate == HIGH);
      r_busy   <= (w_nstate != IDLE) | w_npend;
      r_drop   <= w_ndrop;
    end
  end

  assign o_signal = r_signal;
  assign o_busy   = r_busy;
  assign o_drop   = r_drop;

endmodule

// File: tb/tb_ss_pulse_stretch.sv
// Scoreboard bench for ss_pulse_stretch (WIDTH_CYC=4, GAP_CYC=2).
module tb_ss_pulse_stretch;

  logic clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_pulse = 1'b0;
  logic o_signal;
  logic o_busy;
  logic o_drop;

  int checks = 0;
  int failures = 0;
  logic [2:0] sb_q[$];

  always #5 clk = ~clk;

  ss_pulse_stretch #(
    .WIDTH_CYC(4),
    .GAP_CYC  (2)
  ) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_pulse (i_pulse),
    .o_signal(o_signal),
    .o_busy  (o_busy),
    .o_drop  (o_drop)
  );

  task automatic chk(input string tag, input logic [2:0] got,
                     input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got{sig,busy,drop}=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bit_at(input int c);
    logic [63:0] m;
    m = '0;
    m[c] = 1'b1;
    return m;
  endfunction

  task automatic run(input string name, input logic [63:0] ev,
                     input logic [63:0] sig, input logic [63:0] bsy,
                     input logic [63:0] drp, input logic [63:0] rstm);
    logic [2:0] exp;
    i_rst   = 1'b1;
    i_pulse = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_inreset"}, {o_signal, o_busy, o_drop}, 3'b000);
    @(negedge clk);
    i_rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      i_pulse = ev[c];
      sb_q.push_back({sig[c+1], bsy[c+1], drp[c+1]});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        chk($sformatf("%s_sbempty_c%0d", name, c + 1), 3'b111, 3'b000);
      end else begin
        exp = sb_q.pop_front();
        chk($sformatf("%s_c%0d", name, c + 1),
            {o_signal, o_busy, o_drop}, exp);
      end
      if (rstm[c+1]) begin
        i_pulse = 1'b0;
        i_rst   = 1'b1;
        #1;
        chk($sformatf("%s_asyncrst_c%0d", name, c + 1),
            {o_signal, o_busy, o_drop}, 3'b000);
        @(negedge clk);
        i_rst = 1'b0;
      end
    end
    i_pulse = 1'b0;
  endtask

  initial begin
    run("single", bit_at(10), rng(11, 14), rng(11, 16), '0, '0);
    run("b2b", bit_at(10) | bit_at(12),
        rng(11, 14) | rng(17, 20), rng(11, 22), '0, '0);
    run("ovf", rng(10, 12),
        rng(11, 14) | rng(17, 20), rng(11, 22), bit_at(13), '0);
    run("lastgap", bit_at(10) | bit_at(11) | bit_at(16),
        rng(11, 14) | rng(17, 20) | rng(23, 26), rng(11, 28), '0, '0);
`ifdef SS_PULSE_RETRIGGER_EN
    run("retrig", bit_at(10) | bit_at(13),
        rng(11, 17), rng(11, 19), '0, '0);
`else
    run("noretrig", bit_at(10) | bit_at(13),
        rng(11, 14) | rng(17, 20), rng(11, 22), '0, '0);
`endif
    run("midrst", bit_at(10) | bit_at(20),
        rng(11, 12) | rng(21, 24), rng(11, 12) | rng(21, 26),
        '0, bit_at(12));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ss_pulse_stretch.md
# ss_pulse_stretch

Converts single-cycle event strobes into clean, fixed-width level pulses with a guaranteed minimum low gap between them. It is the generating end of our edge-detection path: the sort control logic emits one-cycle strobes, and this block turns them into waveforms with well-defined rising and falling edges. Downstream synchronizers and edge detectors, including those in other clock or reset domains, can then sample those edges reliably. A one-deep pending latch absorbs events that arrive while a pulse or gap is in progress; further overflow is flagged.

## Interface
Parameters:
- WIDTH_CYC, default 4: high time of each output pulse in i_clk cycles; legal range is ≥1.
- GAP_CYC, default 2: minimum low time after each pulse in cycles; legal range is ≥1.
- CNT_W, default $clog2(max(WIDTH_CYC,GAP_CYC))+1: counter width; derived, never overridden.

Ports:
- i_clk, input, 1: single clock; every register is clocked on its rising edge.
- i_rst, input, 1: reset, asynchronous and active-high.
- i_pulse, input, 1: event strobe; every cycle it is high counts as one event.
- o_signal, output, 1: stretched pulse, registered.
- o_busy, output, 1: high when state ≠ IDLE or an event is pending; registered.
- o_drop, output, 1: one-cycle strobe when an event is discarded; registered.

## Operation
- State machine states are IDLE, HIGH and GAP. There is a down-counter cnt[CNT_W-1:0] and a pending flag pend.
- IDLE: o_signal=0. If i_pulse=1, go to HIGH and load cnt=WIDTH_CYC-1.
- HIGH: o_signal=1 and cnt decrements each cycle. When cnt==0, go to GAP and load cnt=GAP_CYC-1.
- GAP: o_signal=0 and cnt decrements each cycle. When cnt==0:
  - If pend=1: go to HIGH, reload cnt=WIDTH_CYC-1, clear pend.
  - Else if i_pulse=1 in the same cycle: go to HIGH and consume that event.
  - Else: go to IDLE.
- Event arriving in HIGH or GAP (other than the consumed case above):
  - If pend=0: set pend.
  - If pend=1: the event is lost; o_drop=1 on the next cycle.
- Simultaneous event and pend consumption at the last GAP cycle: the pending event starts the new pulse, and the new event sets pend again. No drop occurs.
- o_busy = (next state ≠ IDLE) | next pend, registered so it aligns with o_signal.
- Reset, including mid-pulse: state=IDLE, cnt=0, pend=0, o_signal=0, o_busy=0, o_drop=0, all immediately (asynchronously). The first event after reset release behaves as from IDLE.

## Timing
- Latency: i_pulse high at cycle t (in IDLE) gives o_signal high on cycles t+1 through t+WIDTH_CYC.
- After the pulse, o_signal is low on cycles t+WIDTH_CYC+1 through t+WIDTH_CYC+GAP_CYC.
- The earliest next rising edge is cycle t+WIDTH_CYC+GAP_CYC+1, giving a back-to-back period of WIDTH_CYC+GAP_CYC.
- o_signal never has a high time below WIDTH_CYC or a low time below GAP_CYC between pulses.
- o_drop is asserted exactly one cycle after the dropped event, for one cycle per dropped event.

## Configuration
- Macro: SS_PULSE_RETRIGGER_EN.
- Defined: an event arriving in HIGH reloads cnt=WIDTH_CYC-1, extending the current pulse. It does not set pend and never drops. Events arriving in GAP follow the pend rules as usual.
- Undefined: events in HIGH follow the pend/drop rules above, and pulse width is always exactly WIDTH_CYC.

## Structure
- Shared package ss_pulse_pkg holds the state enum typedef (IDLE/HIGH/GAP, 2-bit) and the CNT_W sizing function.
- No sub-module. The counter, state machine and pend flag sit in a single always_ff next-state/register pair.
- Parameter legality (WIDTH_CYC≥1, GAP_CYC≥1) is checked with an elaboration-time assertion.

## Test plan
- Reset and single event (WIDTH_CYC=4, GAP_CYC=2): outputs are 0 during reset. i_pulse at cycle 10 → o_signal high on cycles 11–14, low from 15. o_busy high on 11–16. o_drop never asserts.
- Back-to-back: i_pulse on cycles 10 and 12 → pulses at 11–14 and 17–20, with gap 15–16. No drop.
- Overflow: i_pulse on cycles 10, 11 and 12 → pulses at 11–14 and 17–20. o_drop=1 on cycle 13 only.
- Last-gap coincidence: event at 10, pend set at 11, event at 16 → pulses at 11–14, 17–20 and 23–26. No drop.
- Retrigger (SS_PULSE_RETRIGGER_EN defined): events at 10 and 13 → o_signal high on 11–17 continuously, then low on 18–19. No drop.
- Reset mid-pulse: event at 10, i_rst asserted during cycle 12 → o_signal low immediately, o_busy=0. Event at 20 after release → pulse at 21–24.
